div_issue_arbiter: RTL
======================

DIV_ISSUE_ARBITER -- requirements
Module: div_issue_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 4, number of requesters sharing one div_unit; RS_ID_WIDTH, default 5, reservation-station tag width; MAX_INFLIGHT, default 4, maximum divides accepted by div_unit and not yet retired.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  [0:NUM_REQ-1]  per-requester divide request.
- req_ready  out  [0:NUM_REQ-1]  per-requester accept.
- req_rs_id  in  [0:NUM_REQ-1][0:RS_ID_WIDTH-1]  per-requester tag.
- req_result_reg_addr  in  [0:NUM_REQ-1][0:4]  per-requester destination GPR.
- req_op1, req_op2, req_xer  in  [0:NUM_REQ-1][0:31]  per-requester operands and XER.
- req_control  in  div_decode_t[0:NUM_REQ-1]  per-requester decode.
- div_input_valid  out  1  request to div_unit.
- div_input_ready  in  1  div_unit accept.
- div_rs_id, div_result_reg_addr, div_op1, div_op2, div_xer, div_control  out  matching widths  muxed payload.
- div_output_valid  in  1  div_unit result valid.
- div_output_ready  out  1  result accept to div_unit.
- out_ready  in  1  downstream (CDB) accept.
- out_src  out  [0:$clog2(NUM_REQ)-1]  requester index owning current div_unit result.
- inflight_count  out  [0:$clog2(MAX_INFLIGHT+1)-1]  divides accepted and not yet retired.

Function
REQ-004 Issue accept SHALL occur when div_input_valid & div_input_ready; retire SHALL occur when div_output_valid & out_ready.
REQ-005 Unlocked arbitration SHALL be round-robin: grant the lowest index i >= rr_ptr with req_valid[i], else wrap to the lowest index < rr_ptr.
REQ-006 div_input_valid SHALL be 1 iff a grant exists and inflight_count < MAX_INFLIGHT.
REQ-007 When div_input_valid = 1 and not accepted, the grant SHALL lock on the next cycle; while locked, the grant index, payload and div_input_valid SHALL stay unchanged regardless of other req_valid.
REQ-008 Payload outputs SHALL be a combinational mux of the granted requester's inputs; with no grant they SHALL be 0.
REQ-009 req_ready[i] SHALL be 1 only for the granted i, and only in the cycle div_input_valid & div_input_ready; all other bits SHALL be 0.
REQ-010 On issue accept: rr_ptr <= (grant+1) mod NUM_REQ; lock cleared; the grant index pushed into a tag FIFO of depth MAX_INFLIGHT.
REQ-011 FSM states: IDLE (no grant, or grant blocked by credit), OFFER (valid shown, unlocked), LOCKED (valid shown, previously refused). Transitions: OFFER -> LOCKED on refusal; OFFER/LOCKED -> IDLE/OFFER on accept; IDLE -> OFFER when a grant exists and credit is available.
REQ-012 div_output_ready SHALL equal out_ready; out_src SHALL be the tag FIFO head; on retire the FIFO SHALL pop.
REQ-013 inflight_count SHALL equal FIFO occupancy: +1 on accept only, -1 on retire only, unchanged on simultaneous accept and retire.
REQ-014 At inflight_count = MAX_INFLIGHT, div_input_valid SHALL be 0 unless locked; credit SHALL be checked at first offer only, so a locked request is never withdrawn.
REQ-015 Simultaneous accept and retire while full SHALL be legal: accept uses a credit taken while count < MAX, and the FIFO pointers wrap modulo MAX_INFLIGHT.
REQ-016 div_output_valid with an empty FIFO SHALL be a protocol error; it SHALL be flagged by a simulation assertion and is not required to be handled.

Reset
REQ-017 On rst: rr_ptr = 0, lock = 0, FSM = IDLE, FIFO empty, inflight_count = 0, div_input_valid = 0, req_ready = 0, out_src = 0.
REQ-018 Assertion of rst mid-operation SHALL discard locked grants and FIFO contents; the first request after deassertion SHALL be arbitrated from index 0.

Verification
REQ-019 Bench SHALL cover: all 4 req_valid held high, div_input_ready=1 -> grants in order 0,1,2,3,0; inflight_count rises to 4 and then div_input_valid=0.
REQ-020 Bench SHALL cover: req 2 offered, div_input_ready=0 for 5 cycles while req 0 rises -> grant stays on 2 with stable payload; req_ready[2] pulses on the accept cycle only.
REQ-021 Bench SHALL cover: issue order 1,3,0 with out_ready=1 -> out_src sequence 1,3,0 matching div_output_valid pulses.
REQ-022 Bench SHALL cover: count=4, then simultaneous retire and a new offer -> count stays 4 at the next accept and FIFO order is preserved across wrap.
REQ-023 Bench SHALL cover: out_ready=0 -> div_output_ready=0, FIFO does not pop, inflight_count held.
REQ-024 Bench SHALL cover: rst asserted while LOCKED with count=2 -> all outputs zero immediately (asynchronous); after release, req 3 and req 0 valid -> grant goes to 0.

Source files
------------

// File: rtl/div_issue_arbiter.sv
// Round-robin issue arbiter sharing one divider among NUM_REQ requesters, with
// a credit-limited tag FIFO that routes each divider result back to its requester.
module div_issue_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int RS_ID_WIDTH  = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CTRL_WIDTH   = 8,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1),
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [0:NUM_REQ-1]                    req_valid,
  output logic [0:NUM_REQ-1]                    req_ready,
  input  logic [0:NUM_REQ-1][0:RS_ID_WIDTH-1]   req_rs_id,
  input  logic [0:NUM_REQ-1][0:4]               req_result_reg_addr,
  input  logic [0:NUM_REQ-1][0:31]              req_op1,
  input  logic [0:NUM_REQ-1][0:31]              req_op2,
  input  logic [0:NUM_REQ-1][0:31]              req_xer,
  input  logic [0:NUM_REQ-1][0:CTRL_WIDTH-1]    req_control,
  output logic                                  div_input_valid,
  input  logic                                  div_input_ready,
  output logic [0:RS_ID_WIDTH-1]                div_rs_id,
  output logic [0:4]                            div_result_reg_addr,
  output logic [0:31]                           div_op1,
  output logic [0:31]                           div_op2,
  output logic [0:31]                           div_xer,
  output logic [0:CTRL_WIDTH-1]                 div_control,
  input  logic                                  div_output_valid,
  output logic                                  div_output_ready,
  input  logic                                  out_ready,
  output logic [0:IDX_W-1]                      out_src,
  output logic [0:CNT_W-1]                      inflight_count
);

  typedef enum logic [1:0] {IDLE, OFFER, LOCKED} state_t;

  state_t           state_q, state_d, cur_state;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] fifo_q [MAX_INFLIGHT];
  logic [IDX_W-1:0] fifo_d [MAX_INFLIGHT];

  logic             hi_found, lo_found, rr_found;
  logic [IDX_W-1:0] hi_idx, lo_idx, rr_idx;
  logic             grant_vld, credit_ok, accept, retire;
  logic [IDX_W-1:0] grant_idx;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest below it.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k] && (k >= int'(rr_ptr_q))) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(k);
      end
      if (req_valid[k] && (k < int'(rr_ptr_q))) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(k);
      end
    end
    rr_found = hi_found | lo_found;
    rr_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Offer FSM: credit is only consulted before the first offer, so a
  // refused (locked) request is held until the divider takes it.
  always_comb begin
    credit_ok = (count_q < CNT_W'(MAX_INFLIGHT));
    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      grant_vld = rr_found;
      grant_idx = rr_idx;
    end
    if (rst) begin
      grant_vld = 1'b0;
    end

    if (grant_vld && (state_q == LOCKED)) begin
      cur_state = LOCKED;
    end else if (grant_vld && credit_ok) begin
      cur_state = OFFER;
    end else begin
      cur_state = IDLE;
    end

    div_input_valid = (cur_state != IDLE);
    accept          = div_input_valid & div_input_ready;
    retire          = div_output_valid & out_ready & (count_q != '0);

    state_d    = IDLE;
    lock_idx_d = lock_idx_q;
    case (cur_state)
      OFFER, LOCKED: begin
        state_d    = accept ? IDLE : LOCKED;
        lock_idx_d = grant_idx;
      end
      default: state_d = IDLE;
    endcase

    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end

    div_rs_id           = '0;
    div_result_reg_addr = '0;
    div_op1             = '0;
    div_op2             = '0;
    div_xer             = '0;
    div_control         = '0;
    if (grant_vld) begin
      div_rs_id           = req_rs_id[grant_idx];
      div_result_reg_addr = req_result_reg_addr[grant_idx];
      div_op1             = req_op1[grant_idx];
      div_op2             = req_op2[grant_idx];
      div_xer             = req_xer[grant_idx];
      div_control         = req_control[grant_idx];
    end
  end

  // Tag FIFO bookkeeping; pointers wrap modulo MAX_INFLIGHT, not a power of two.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fifo_d   = fifo_q;

    if (accept) begin
      rr_ptr_d         = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      fifo_d[wr_ptr_q] = grant_idx;
      wr_ptr_d         = (wr_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (retire) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({accept, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign div_output_ready = out_ready;
  assign out_src          = (count_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign inflight_count   = count_q;

  a_result_without_tag: assert property (
    @(posedge clk) disable iff (rst) div_output_valid |-> (count_q != '0)
  );

endmodule
